// File: rtl/pc_ir_if.sv
// Signal bundle between the PC/IR front end and the rest of the multicycle core:
// control-unit strobes, ALU results, memory handshakes and the front-end outputs.
interface pc_ir_if;
  logic [3:0]  next_state;
  logic        cu_irwrite;
  logic        cu_pcwrite;
  logic [1:0]  cu_pcsrc;
  logic        cu_branch;
  logic [31:0] alu_result;
  logic        alu_zero;
  logic [31:0] imem_rdata;
  logic        imem_ready;
  logic        dmem_ready;

  logic        imem_req;
  logic [31:0] imem_addr;
  logic [3:0]  state;
  logic [31:0] pc;
  logic [31:0] old_pc;
  logic [31:0] ir;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] link_addr;
  logic        misalign;

  // The front end itself.
  modport master (
    input  next_state, cu_irwrite, cu_pcwrite, cu_pcsrc, cu_branch,
           alu_result, alu_zero, imem_rdata, imem_ready, dmem_ready,
    output imem_req, imem_addr, state, pc, old_pc, ir,
           opcode, funct3, funct7, link_addr, misalign
  );

  // Control unit, ALU and memories around it.
  modport slave (
    output next_state, cu_irwrite, cu_pcwrite, cu_pcsrc, cu_branch,
           alu_result, alu_zero, imem_rdata, imem_ready, dmem_ready,
    input  imem_req, imem_addr, state, pc, old_pc, ir,
           opcode, funct3, funct7, link_addr, misalign
  );
endinterface

// File: rtl/pc_ir_unit.sv
// Sequential front end of the multicycle RISC-V core: PC, old_pc, IR and the
// FSM state register, with instruction/data memory wait-state stalls.
module pc_ir_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INSN = 32'h0000_0013
) (
  input  logic     clk,
  input  logic     rst_n,
  pc_ir_if.master  bus
);

  localparam logic [3:0] ST_FETCH = 4'd0;
  localparam logic [3:0] ST_STORE = 4'd8;
  localparam logic [3:0] ST_LOAD  = 4'd9;
  localparam logic [3:0] ST_LAST  = 4'd11;

  // What the current cycle does to the state register.
  typedef enum logic [1:0] {
    ADV_HOLD,
    ADV_STEP,
    ADV_TRAP
  } adv_e;

  logic [3:0]  r_state;
  logic [31:0] r_pc;
  logic [31:0] r_old_pc;
  logic [31:0] r_ir;
  logic        r_misalign;

  adv_e        w_adv;
  logic [3:0]  w_state_nxt;
  logic        w_taken;
  logic        w_pc_we;
  logic        w_ir_we;
  logic [31:0] w_imm_b;
  logic [31:0] w_imm_j;
  logic [31:0] w_pc_target;

  // NOTE: every signal assigned in always_comb gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    w_adv = ADV_STEP;
    if (r_state > ST_LAST)
      w_adv = ADV_TRAP;
    else if ((r_state == ST_FETCH) && !bus.imem_ready)
      w_adv = ADV_HOLD;
    else if (((r_state == ST_STORE) || (r_state == ST_LOAD)) && !bus.dmem_ready)
      w_adv = ADV_HOLD;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (w_adv)
      ADV_STEP: w_state_nxt = bus.next_state;
      ADV_TRAP: w_state_nxt = ST_FETCH;
      default:  w_state_nxt = r_state;
    endcase
  end

  // The ALU leaves the signed/unsigned compare result in bit 0.
  always_comb begin
    w_taken = 1'b0;
    case (r_ir[14:12])
      3'b000:                      w_taken = bus.alu_zero;
      3'b001:                      w_taken = !bus.alu_zero;
      3'b100, 3'b101, 3'b110, 3'b111: w_taken = bus.alu_result[0];
      default:                     w_taken = 1'b0;
    endcase
  end

  assign w_imm_b = {{19{r_ir[31]}}, r_ir[31], r_ir[7], r_ir[30:25], r_ir[11:8], 1'b0};
  assign w_imm_j = {{11{r_ir[31]}}, r_ir[31], r_ir[19:12], r_ir[20], r_ir[30:21], 1'b0};

  always_comb begin
    w_pc_target = bus.alu_result;
    case (bus.cu_pcsrc)
      2'b00:   w_pc_target = bus.alu_result;
      2'b01:   w_pc_target = r_old_pc + w_imm_b;
      2'b10:   w_pc_target = r_old_pc + w_imm_j;
      default: w_pc_target = {bus.alu_result[31:1], 1'b0};
    endcase
  end

  // An unconditional write wins over the branch decision.
  assign w_pc_we = (w_adv == ADV_STEP) && (bus.cu_pcwrite || (bus.cu_branch && w_taken));
  assign w_ir_we = (r_state == ST_FETCH) && (w_adv == ADV_STEP) && bus.cu_irwrite;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_FETCH;
      r_pc       <= RESET_PC;
      r_old_pc   <= RESET_PC;
      r_ir       <= NOP_INSN;
      r_misalign <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_ir_we) begin
        r_ir     <= bus.imem_rdata;
        r_old_pc <= r_pc;
      end
      if (w_pc_we) begin
        r_pc <= w_pc_target;
        if (w_pc_target[1:0] != 2'b00)
          r_misalign <= 1'b1;
      end
    end
  end

  assign bus.imem_req  = (r_state == ST_FETCH) && rst_n;
  assign bus.imem_addr = r_pc;
  assign bus.state     = r_state;
  assign bus.pc        = r_pc;
  assign bus.old_pc    = r_old_pc;
  assign bus.ir        = r_ir;
  assign bus.opcode    = r_ir[6:0];
  assign bus.funct3    = r_ir[14:12];
  assign bus.funct7    = r_ir[31:25];
  assign bus.link_addr = r_old_pc + 32'd4;
  assign bus.misalign  = r_misalign;

endmodule

// File: tb/tb_pc_ir_unit.sv
// Self-checking bench for pc_ir_unit: directed scenarios with literal
// expectations, then randomized traffic checked against a behavioural model.
module tb_pc_ir_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP_INSN = 32'h0000_0013;

  logic clk;
  logic rst_n;
  pc_ir_if bus ();

  pc_ir_unit #(.RESET_PC(RESET_PC), .NOP_INSN(NOP_INSN)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;
  logic cmp_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  logic [3:0]  m_state;
  logic [31:0] m_pc, m_old_pc, m_ir;
  logic        m_mis;

  function automatic logic br_taken(input logic [2:0] f3, input logic z, input logic [31:0] alu);
    if (f3 == 3'd0) return z;
    if (f3 == 3'd1) return !z;
    if (f3 >= 3'd4) return alu[0];
    return 1'b0;
  endfunction

  function automatic logic [31:0] pc_target(input logic [1:0] src, input logic [31:0] alu,
                                            input logic [31:0] opc, input logic [31:0] insn);
    int off;
    case (src)
      2'd0: return alu;
      2'd1: begin
        off = (insn[31] ? -4096 : 0) + (int'(insn[7]) << 11)
            + (int'(insn[30:25]) << 5) + (int'(insn[11:8]) << 1);
        return opc + 32'(off);
      end
      2'd2: begin
        off = (insn[31] ? -(1 << 20) : 0) + (int'(insn[19:12]) << 12)
            + (int'(insn[20]) << 11) + (int'(insn[30:21]) << 1);
        return opc + 32'(off);
      end
      default: return alu - 32'(alu % 2);
    endcase
  endfunction

  function automatic logic waiting(input logic [3:0] st, input logic iready, input logic dready);
    if (st == 4'd0) return !iready;
    if (st == 4'd8 || st == 4'd9) return !dready;
    return 1'b0;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_state  <= 4'd0;
      m_pc     <= RESET_PC;
      m_old_pc <= RESET_PC;
      m_ir     <= NOP_INSN;
      m_mis    <= 1'b0;
    end else if (m_state > 4'd11) begin
      m_state <= 4'd0;
    end else if (!waiting(m_state, bus.imem_ready, bus.dmem_ready)) begin
      if (m_state == 4'd0 && bus.cu_irwrite) begin
        m_ir     <= bus.imem_rdata;
        m_old_pc <= m_pc;
      end
      if (bus.cu_pcwrite || (bus.cu_branch && br_taken(m_ir[14:12], bus.alu_zero, bus.alu_result))) begin
        m_pc <= pc_target(bus.cu_pcsrc, bus.alu_result, m_old_pc, m_ir);
        if (pc_target(bus.cu_pcsrc, bus.alu_result, m_old_pc, m_ir) % 4 != 0) m_mis <= 1'b1;
      end
      m_state <= bus.next_state;
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (cmp_en) begin
      check("state",     {28'd0, bus.state}, {28'd0, m_state});
      check("pc",        bus.pc,        m_pc);
      check("imem_addr", bus.imem_addr, m_pc);
      check("old_pc",    bus.old_pc,    m_old_pc);
      check("ir",        bus.ir,        m_ir);
      check("opcode",    {25'd0, bus.opcode}, {25'd0, m_ir[6:0]});
      check("funct3",    {29'd0, bus.funct3}, {29'd0, m_ir[14:12]});
      check("funct7",    {25'd0, bus.funct7}, {25'd0, m_ir[31:25]});
      check("link_addr", bus.link_addr, m_old_pc + 32'd4);
      check("misalign",  {31'd0, bus.misalign}, {31'd0, m_mis});
      check("imem_req",  {31'd0, bus.imem_req}, {31'd0, (m_state == 4'd0) && rst_n});
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic drive(input logic [3:0] ns, input logic irw, input logic pcw, input logic [1:0] src,
                       input logic br, input logic [31:0] alu, input logic z, input logic [31:0] rd,
                       input logic ir_rdy, input logic d_rdy);
    bus.next_state = ns;
    bus.cu_irwrite = irw;
    bus.cu_pcwrite = pcw;
    bus.cu_pcsrc   = src;
    bus.cu_branch  = br;
    bus.alu_result = alu;
    bus.alu_zero   = z;
    bus.imem_rdata = rd;
    bus.imem_ready = ir_rdy;
    bus.dmem_ready = d_rdy;
  endtask

  task automatic idle();
    drive(4'd0, 1'b0, 1'b0, 2'd0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0);
  endtask

  // One active edge, then park just after the following falling edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    // Fetch inputs present during reset must not be taken.
    drive(4'd1, 1'b1, 1'b1, 2'd0, 1'b0, 32'd4, 1'b0, 32'h0050_0093, 1'b1, 1'b0);
    tick();
    cmp_en = 1'b1;
    tick();
    check("rst pc",       bus.pc, RESET_PC);
    check("rst ir",       bus.ir, NOP_INSN);
    check("rst state",    {28'd0, bus.state}, 32'd0);
    check("rst imem_req", {31'd0, bus.imem_req}, 32'd0);

    rst_n = 1'b1;
    tick();
    check("fetch ir",     bus.ir, 32'h0050_0093);
    check("fetch old_pc", bus.old_pc, 32'd0);
    check("fetch pc",     bus.pc, 32'd4);
    check("fetch state",  {28'd0, bus.state}, 32'd1);
    check("fetch opcode", {25'd0, bus.opcode}, 32'h13);
    idle();
    tick();

    // Instruction memory wait states.
    drive(4'd0, 1'b1, 1'b1, 2'd0, 1'b0, 32'd8, 1'b0, 32'h00A0_0113, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall state", {28'd0, bus.state}, 32'd0);
      check("stall pc",    bus.pc, 32'd4);
      check("stall req",   {31'd0, bus.imem_req}, 32'd1);
    end
    bus.imem_ready = 1'b1;
    tick();
    check("stall done pc", bus.pc, 32'd8);
    check("stall done ir", bus.ir, 32'h00A0_0113);

    // BEQ -4 from old_pc 8.
    drive(4'd5, 1'b1, 1'b1, 2'd0, 1'b0, 32'd12, 1'b0, 32'hFE00_0EE3, 1'b1, 1'b0);
    tick();
    check("beq old_pc", bus.old_pc, 32'd8);
    drive(4'd5, 1'b0, 1'b0, 2'd1, 1'b1, 32'd0, 1'b1, 32'd0, 1'b0, 1'b0);
    tick();
    check("beq taken pc", bus.pc, 32'd4);
    drive(4'd0, 1'b0, 1'b0, 2'd1, 1'b1, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0);
    tick();
    check("beq not taken pc", bus.pc, 32'd4);

    // JAL +8 from 16, then JALR to a misaligned target.
    drive(4'd0, 1'b1, 1'b1, 2'd0, 1'b0, 32'd16, 1'b0, NOP_INSN, 1'b1, 1'b0);
    tick();
    drive(4'd6, 1'b1, 1'b1, 2'd0, 1'b0, 32'd20, 1'b0, 32'h0080_00EF, 1'b1, 1'b0);
    tick();
    check("jal link", bus.link_addr, 32'd20);
    drive(4'd6, 1'b0, 1'b1, 2'd2, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0);
    tick();
    check("jal pc", bus.pc, 32'd24);
    check("jal misalign", {31'd0, bus.misalign}, 32'd0);
    drive(4'd0, 1'b0, 1'b1, 2'd3, 1'b0, 32'h103, 1'b0, 32'd0, 1'b0, 1'b0);
    tick();
    check("jalr pc", bus.pc, 32'h102);
    check("jalr misalign", {31'd0, bus.misalign}, 32'd1);

    // Load with data memory wait states; PC write must not land while held.
    drive(4'd9, 1'b1, 1'b1, 2'd0, 1'b0, 32'h106, 1'b0, 32'h0000_2083, 1'b1, 1'b0);
    tick();
    drive(4'd10, 1'b0, 1'b1, 2'd0, 1'b0, 32'h200, 1'b0, 32'd0, 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) begin
      tick();
      check("load hold state", {28'd0, bus.state}, 32'd9);
      check("load hold pc", bus.pc, 32'h106);
    end
    bus.dmem_ready = 1'b1;
    bus.cu_pcwrite = 1'b0;
    tick();
    check("load go state", {28'd0, bus.state}, 32'd10);
    idle();
    tick();

    // Store held, then asynchronous reset between edges.
    drive(4'd8, 1'b1, 1'b1, 2'd0, 1'b0, 32'h10A, 1'b0, NOP_INSN, 1'b1, 1'b0);
    tick();
    idle();
    tick();
    check("store hold state", {28'd0, bus.state}, 32'd8);
    rst_n = 1'b0;
    #2;
    check("async pc",       bus.pc, RESET_PC);
    check("async old_pc",   bus.old_pc, RESET_PC);
    check("async ir",       bus.ir, NOP_INSN);
    check("async state",    {28'd0, bus.state}, 32'd0);
    check("async misalign", {31'd0, bus.misalign}, 32'd0);
    check("async req",      {31'd0, bus.imem_req}, 32'd0);
    @(negedge clk);
    #1;
    rst_n = 1'b1;

    // Illegal state recovers to fetch with no writes.
    drive(4'd13, 1'b1, 1'b1, 2'd0, 1'b0, 32'd4, 1'b0, NOP_INSN, 1'b1, 1'b0);
    tick();
    check("illegal entry", {28'd0, bus.state}, 32'd13);
    drive(4'd5, 1'b1, 1'b1, 2'd0, 1'b0, 32'h40, 1'b0, 32'hDEAD_BEEF, 1'b1, 1'b1);
    tick();
    check("illegal state", {28'd0, bus.state}, 32'd0);
    check("illegal pc", bus.pc, 32'd4);
    check("illegal ir", bus.ir, NOP_INSN);

    // Address wrap at the top of memory.
    drive(4'd0, 1'b1, 1'b1, 2'd0, 1'b0, 32'hFFFF_FFFC, 1'b0, NOP_INSN, 1'b1, 1'b0);
    tick();
    drive(4'd6, 1'b1, 1'b1, 2'd0, 1'b0, 32'd0, 1'b0, 32'h0080_00EF, 1'b1, 1'b0);
    tick();
    check("wrap pc", bus.pc, 32'd0);
    check("wrap link", bus.link_addr, 32'd0);
    drive(4'd0, 1'b0, 1'b1, 2'd2, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0);
    tick();
    check("wrap jal pc", bus.pc, 32'd4);
    check("wrap misalign", {31'd0, bus.misalign}, 32'd0);

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      rst_n = ($urandom_range(0, 199) != 0);
      bus.next_state = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(12, 15))
                                                   : 4'($urandom_range(0, 11));
      bus.cu_irwrite = 1'($urandom_range(0, 3) != 0);
      bus.cu_pcwrite = 1'($urandom_range(0, 2) == 0);
      bus.cu_pcsrc   = 2'($urandom_range(0, 3));
      bus.cu_branch  = 1'($urandom_range(0, 2) == 0);
      bus.alu_result = ($urandom_range(0, 3) != 0) ? ($urandom() & 32'hFFFF_FFFC) : $urandom();
      bus.alu_zero   = 1'($urandom_range(0, 1));
      bus.imem_rdata = $urandom();
      bus.imem_ready = 1'($urandom_range(0, 9) < 7);
      bus.dmem_ready = 1'($urandom_range(0, 1));
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/pc_ir_unit.md
Name: pc_ir_unit

Overview:
- Sequential front end of the multicycle RISC-V core.
- Holds the architectural PC, the PC of the instruction in flight (old_pc), the instruction register (IR) and the FSM state register that feeds the control unit's State input.
- Consumes the control unit's PC/IR/branch strobes and Next_State.
- Owns the instruction-memory handshake, and stalls state advance on instruction- and data-memory wait states.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NOP_INSN, 32'h0000_0013, IR value on reset (addi x0,x0,0).

Ports:
- clk  in  1  core clock, rising edge
- rst  in  1  asynchronous, active-low reset (rst=0 resets)
- next_state  in  4  control unit Next_State
- cu_irwrite  in  1  IR load enable (fetch state)
- cu_pcwrite  in  1  unconditional PC write
- cu_pcsrc  in  2  PC source select
- cu_branch  in  1  conditional branch state
- alu_result  in  32  ALU output
- alu_zero  in  1  ALU zero flag
- imem_rdata  in  32  instruction read data
- imem_ready  in  1  instruction data valid this cycle
- dmem_ready  in  1  data access complete this cycle
- imem_req  out  1  instruction fetch request
- imem_addr  out  32  fetch address (= pc)
- state  out  4  current FSM state, to control unit
- pc  out  32  architectural PC
- old_pc  out  32  PC of the current instruction
- ir  out  32  instruction register
- opcode  out  7  ir[6:0]
- funct3  out  3  ir[14:12]
- funct7  out  7  ir[31:25]
- link_addr  out  32  old_pc + 4, for JAL/JALR writeback
- misalign  out  1  sticky flag: a PC target with bits[1:0] != 0 was written

Behaviour:
- Reset (rst=0, async): pc=RESET_PC, old_pc=RESET_PC, ir=NOP_INSN, state=0, misalign=0. imem_req is 0 while rst=0. Deasserting rst mid-fetch drops any outstanding request; the bench must see no IR/PC update from it.
- Decoded fields and link_addr are combinational from ir/old_pc.
- imem_req=1 iff state==0 and not in reset; imem_addr=pc.
- State 0 (fetch) completes only in a cycle with imem_ready=1:
  - ir<=imem_rdata and old_pc<=pc, both gated by cu_irwrite.
  - If cu_pcwrite: pc<=alu_result, expected to be PC+4.
  - state<=next_state.
- State 0 with imem_ready=0: nothing updates, state stays 0. This is an unbounded stall.
- States 8 (store) and 9 (load read) advance only when dmem_ready=1. Otherwise the state holds and no PC write occurs.
- All other states 1..11 advance every cycle: state<=next_state.
- state>11 is illegal: next edge forces state=0 with no PC/IR write.
- PC target select, applied when a write is enabled and the state is advancing:
  - pcsrc 00: alu_result.
  - pcsrc 01: old_pc + imm_b, where imm_b = sext({ir[31],ir[7],ir[30:25],ir[11:8],1'b0}).
  - pcsrc 10: old_pc + imm_j, where imm_j = sext({ir[31],ir[19:12],ir[20],ir[30:21],1'b0}).
  - pcsrc 11: {alu_result[31:1],1'b0} (JALR).
- PC write enable = cu_pcwrite | (cu_branch & taken).
- Branch taken decision:
  - funct3 000: taken = alu_zero.
  - funct3 001: taken = !alu_zero.
  - funct3 100/101/110/111: taken = alu_result[0]. The ALU returns the compare result in bit 0.
  - funct3 010/011: taken = 0.
- All additions are modulo 2^32; wrap from 32'hFFFF_FFFC+4 gives 0 and raises no flag.
- misalign is set when a written PC value has bits[1:0] != 0. It is cleared only by reset. The PC is still written with the value.
- If cu_pcwrite and cu_branch are both 1, the write occurs regardless of taken.

Test Plan:
- Reset with rst=0, then release; imem_ready=1, rdata=32'h00500093, alu_result=4, pcwrite=1, next_state=1 → after one edge: ir=32'h00500093, old_pc=0, pc=4, state=1, opcode=7'h13.
- Fetch with imem_ready=0 for 3 cycles, then 1 → state stays 0 and pc unchanged for 3 edges; imem_req=1 throughout; update occurs on the 4th edge.
- BEQ: ir=32'hFE000EE3 (offset −4), old_pc=8, state=5, branch=1, pcsrc=01, funct3=000. With alu_zero=1 → pc=4. Repeat with alu_zero=0 → pc unchanged.
- JAL: ir=32'h008000EF, old_pc=16, state=6, pcwrite=1, pcsrc=10 → pc=24, link_addr=20. JALR with pcsrc=11 and alu_result=32'h103 → pc=32'h102 and misalign=1.
- Load stall: state=9, dmem_ready=0 for 2 cycles → state holds at 9. dmem_ready=1 → state=next_state (10).
- Async reset asserted mid-stall in state 8 → outputs return to reset values immediately, without waiting for a clock edge. Also force state=13 → next edge state=0.
